// File: rtl/array_1_ctrl_pkg.sv
// rtl/array_1_ctrl_pkg.sv - shared defaults and FSM state codes for the array_1 clear/arbitration controller
package array_1_ctrl_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 20;
  localparam int LANES_DEF  = 2;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/array_1_ctrl_rr_arb2.sv
// rtl/array_1_ctrl_rr_arb2.sv - two-request round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr names the client that wins when both request
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)     ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end

endmodule

// File: rtl/array_1_ctrl.sv
// rtl/array_1_ctrl.sv - memory clear sequencer, read arbiter and write pass-through for an external array
module array_1_ctrl
  import array_1_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd0_valid,
  output logic              rd0_ready,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd1_valid,
  output logic              rd1_ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              clear_req,
  output logic              init_busy,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic [LANES-1:0]  mem_w_mask,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run;
  logic [1:0]        gnt;

  assign run = !reset && (state == ST_RUN);

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .en    (run),
    .req   ({rd1_valid, rd0_valid}),
    .gnt   (gnt)
  );

  assign rd0_ready  = gnt[0];
  assign rd1_ready  = gnt[1];
  assign wr_ready   = run;
  assign init_busy  = reset || (state == ST_INIT);
  assign mem_r_en   = |gnt;
  assign mem_r_addr = gnt[1] ? rd1_addr : rd0_addr;
  // memory is write-first, so same-address read/write needs no forwarding here
  assign resp_data  = mem_r_data;

  always_comb begin
    mem_w_en   = 1'b0;
    mem_w_addr = wr_addr;
    mem_w_data = wr_data;
    mem_w_mask = wr_mask;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_w_en   = 1'b1;
        mem_w_addr = clr_cnt;
        mem_w_data = '0;
        mem_w_mask = '1;
      end else begin
        mem_w_en   = wr_valid;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      clr_cnt     <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      resp0_valid <= gnt[0];
      resp1_valid <= gnt[1];
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state   <= ST_RUN;
          clr_cnt <= '0;
        end
      end else if (clear_req) begin
        state   <= ST_INIT;
        clr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_array_1_ctrl.sv
// tb/tb_array_1_ctrl.sv - randomized bench for array_1_ctrl with a behavioural array and controller model
module tb_array_1_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 20;
  localparam int LN    = 2;
  localparam int LW    = DW / LN;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd0_valid, rd1_valid, wr_valid, clear_req;
  logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [LN-1:0] wr_mask;
  logic          rd0_ready, rd1_ready, resp0_valid, resp1_valid, wr_ready, init_busy;
  logic [DW-1:0] resp_data;
  logic          mem_w_en, mem_r_en;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [DW-1:0] mem_w_data, mem_r_data;
  logic [LN-1:0] mem_w_mask;

  always #5 clock = ~clock;

  array_1_ctrl dut (
    .clock(clock), .reset(reset),
    .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .clear_req(clear_req), .init_busy(init_busy),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [LN-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < LN; l++)
      if (m[l]) r[l*LW +: LW] = nw[l*LW +: LW];
    return r;
  endfunction

  // sibling array: registered read address, write-first on collision
  logic [DW-1:0] tmem [DEPTH];
  always @(posedge clock) begin
    if (mem_w_en) tmem[mem_w_addr] <= merge(tmem[mem_w_addr], mem_w_data, mem_w_mask);
    if (mem_r_en)
      mem_r_data <= (mem_w_en && mem_w_addr == mem_r_addr) ?
                    merge(tmem[mem_r_addr], mem_w_data, mem_w_mask) : tmem[mem_r_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model: array contents, clear cycles remaining, last granted client, pending response
  logic [DW-1:0] ref_mem [DEPTH];
  int            init_left = DEPTH;
  int            last_gnt  = 1;
  bit            pend0, pend1;
  logic [DW-1:0] pend_data;

  logic          obs_r0, obs_r1, obs_resp0, obs_resp1, obs_busy;
  logic [DW-1:0] obs_data;

  task automatic step();
    bit e_busy, e_wen, e_ren, e_r0, e_r1;
    int g;
    logic [AW-1:0] e_waddr, g_addr;
    #4;
    g = -1;
    e_busy = 1'b1; e_wen = 1'b0; e_ren = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
    e_waddr = '0;
    if (!reset) begin
      if (init_left > 0) begin
        e_wen   = 1'b1;
        e_waddr = AW'(DEPTH - init_left);
      end else begin
        e_busy = 1'b0;
        e_wen  = wr_valid;
        if (rd0_valid && rd1_valid) g = (last_gnt == 0) ? 1 : 0;
        else if (rd0_valid)         g = 0;
        else if (rd1_valid)         g = 1;
        e_r0  = (g == 0);
        e_r1  = (g == 1);
        e_ren = (g >= 0);
      end
    end
    g_addr = (g == 1) ? rd1_addr : rd0_addr;

    check("init_busy", 32'(init_busy), 32'(e_busy));
    check("rd0_ready", 32'(rd0_ready), 32'(e_r0));
    check("rd1_ready", 32'(rd1_ready), 32'(e_r1));
    check("wr_ready", 32'(wr_ready), 32'(!e_busy));
    check("mem_w_en", 32'(mem_w_en), 32'(e_wen));
    check("mem_r_en", 32'(mem_r_en), 32'(e_ren));
    check("resp0_valid", 32'(resp0_valid), 32'(pend0));
    check("resp1_valid", 32'(resp1_valid), 32'(pend1));
    if (pend0 || pend1) check("resp_data", 32'(resp_data), 32'(pend_data));
    if (e_wen && init_left > 0 && !reset) begin
      check("clr_addr", 32'(mem_w_addr), 32'(e_waddr));
      check("clr_data", 32'(mem_w_data), 32'h0);
      check("clr_mask", 32'(mem_w_mask), 32'h3);
    end else if (e_wen) begin
      check("wr_addr", 32'(mem_w_addr), 32'(wr_addr));
      check("wr_data", 32'(mem_w_data), 32'(wr_data));
      check("wr_mask", 32'(mem_w_mask), 32'(wr_mask));
    end
    if (e_ren) check("rd_addr", 32'(mem_r_addr), 32'(g_addr));

    obs_r0 = rd0_ready; obs_r1 = rd1_ready; obs_resp0 = resp0_valid;
    obs_resp1 = resp1_valid; obs_busy = init_busy; obs_data = resp_data;

    if (reset) begin
      init_left = DEPTH; last_gnt = 1; pend0 = 1'b0; pend1 = 1'b0;
    end else if (init_left > 0) begin
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
      pend0 = 1'b0; pend1 = 1'b0;
    end else begin
      if (wr_valid) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_mask);
      pend0 = (g == 0); pend1 = (g == 1);
      if (g >= 0) begin
        pend_data = ref_mem[g_addr];
        last_gnt  = g;
      end
      if (clear_req) init_left = DEPTH;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rd0_valid = 1'b0; rd1_valid = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
  endtask

  // hold rd0 on addr until granted; returns cycles waited
  task automatic wait_grant(input logic [AW-1:0] addr, output int n);
    idle();
    rd0_valid = 1'b1; rd0_addr = addr;
    n = 0;
    step();
    while (!obs_r0 && n < 400) begin
      n++;
      step();
    end
    if (n >= 400) check("grant_timeout", 32'(n), 32'd0);
    idle();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle();
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    @(posedge clock); #1;
    step(); step();
    reset = 1'b0;

    wait_grant(8'h7F, n);
    check("init_len", 32'(n), 32'd256);
    step();
    check("rd_7f_valid", 32'(obs_resp0), 32'd1);
    check("rd_7f_data", 32'(obs_data), 32'h0);

    rd0_valid = 1'b1; rd0_addr = 8'h10; rd1_valid = 1'b1; rd1_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_onehot", 32'(obs_r0 ^ obs_r1), 32'd1);
      check("rr_alt", 32'(obs_r1), 32'((i % 2) == 0));
    end
    idle();

    wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 20'hABCDE; wr_mask = 2'b01;
    step();
    idle(); rd1_valid = 1'b1; rd1_addr = 8'h05;
    step();
    idle();
    step();
    check("mask_resp", 32'(obs_resp1), 32'd1);
    check("mask_data", 32'(obs_data), 32'h000DE);

    wr_valid = 1'b1; wr_addr = 8'h33; wr_data = 20'h12345; wr_mask = 2'b11;
    rd0_valid = 1'b1; rd0_addr = 8'h33;
    step();
    idle();
    step();
    check("wf_data", 32'(obs_data), 32'h12345);

    rd0_valid = 1'b1; rd0_addr = 8'h33; clear_req = 1'b1;
    step();
    check("clr_grant", 32'(obs_r0), 32'd1);
    idle();
    step();
    check("clr_resp", 32'(obs_resp0), 32'd1);
    check("clr_busy", 32'(obs_busy), 32'd1);
    check("clr_resp_data", 32'(obs_data), 32'h12345);
    wait_grant(8'h33, n);
    check("clr_len", 32'(n), 32'd255);
    step();
    check("clr_readback", 32'(obs_data), 32'h0);

    clear_req = 1'b1;
    step();
    idle();
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_grant(8'h05, n);
    check("rst_mid_len", 32'(n), 32'd256);
    step();
    check("rst_mid_data", 32'(obs_data), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rd0_valid = ($urandom_range(0, 2) != 0);
      rd1_valid = ($urandom_range(0, 2) != 0);
      rd0_addr  = AW'($urandom_range(0, 15));
      rd1_addr  = AW'($urandom_range(0, 15));
      wr_valid  = ($urandom_range(0, 1) != 0);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = DW'($urandom);
      wr_mask   = LN'($urandom_range(0, 3));
      clear_req = ($urandom_range(0, 299) == 0) || (init_left > 0 && $urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_1_ctrl.md
ARRAY_1_CTRL -- requirements
Module: array_1_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of memory entries.
REQ-002 SHALL have parameter ADDR_W, default 8, address width (log2 DEPTH).
REQ-003 SHALL have parameter DATA_W, default 20, entry width.
REQ-004 SHALL have parameter LANES, default 2, write-mask lanes; lane width DATA_W/LANES.
REQ-005 SHALL have port clock  in  1  sole clock; also drives both memory port clocks externally.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports rd0_valid in 1, rd0_ready out 1, rd0_addr in ADDR_W; read client 0 request.
REQ-008 SHALL have ports rd1_valid in 1, rd1_ready out 1, rd1_addr in ADDR_W; read client 1 request.
REQ-009 SHALL have ports resp0_valid out 1, resp1_valid out 1, resp_data out DATA_W; read response, no back-pressure.
REQ-010 SHALL have ports wr_valid in 1, wr_ready out 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_mask in LANES; write client.
REQ-011 SHALL have port clear_req in 1; single-cycle pulse requesting full memory clear.
REQ-012 SHALL have port init_busy out 1; high while clearing.
REQ-013 SHALL have ports mem_w_en out 1, mem_w_addr out ADDR_W, mem_w_data out DATA_W, mem_w_mask out LANES; memory write port.
REQ-014 SHALL have ports mem_r_en out 1, mem_r_addr out ADDR_W, mem_r_data in DATA_W; memory read port (address registered inside memory, data valid cycle after mem_r_en).

Function
REQ-015 SHALL implement FSM states INIT and RUN.
REQ-016 INIT: mem_w_en=1, mem_w_addr=clear counter, mem_w_data=0, mem_w_mask=all ones; counter +1 per cycle.
REQ-017 INIT->RUN in cycle after counter=DEPTH-1 written; INIT lasts exactly DEPTH cycles.
REQ-018 In INIT: rd0_ready=rd1_ready=wr_ready=0, mem_r_en=0, init_busy=1.
REQ-019 RUN->INIT on clear_req=1; requests presented that cycle are still accepted; counter restarts at 0.
REQ-020 clear_req during INIT SHALL be ignored (no restart).
REQ-021 RUN: wr_ready=1; wr_valid passes through combinationally to mem_w_en/addr/data/mask same cycle.
REQ-022 RUN: at most one read grant per cycle, round-robin between clients 0 and 1.
REQ-023 Only one client valid -> that client granted; both valid -> client not granted most recently; priority pointer updates only on grant.
REQ-024 rdN_ready SHALL equal the grant to client N (combinational, RUN only); mem_r_en=1 and mem_r_addr=granted address on grant.
REQ-025 Response SHALL follow grant by exactly 1 cycle: respN_valid=1 for one cycle, resp_data=mem_r_data.
REQ-026 Read and write to same address same cycle: response carries post-write data with masked lanes merged (memory write-first); controller adds no forwarding.
REQ-027 Grant in the cycle clear_req asserts SHALL still produce its response in the following (INIT) cycle.
REQ-028 resp_data SHALL be don't-care when both resp valids are 0.

Reset
REQ-029 reset=1 SHALL force next state INIT, clear counter=0, priority pointer to client 0, resp0_valid=resp1_valid=0.
REQ-030 While reset=1: mem_w_en=0, mem_r_en=0, all readies 0, init_busy=1.
REQ-031 reset mid-INIT or mid-RUN SHALL restart clearing from address 0; pending response discarded.

Structure
REQ-032 Shared package SHALL hold DEPTH/ADDR_W/DATA_W/LANES defaults and the state enumeration.
REQ-033 Round-robin logic SHALL be sub-module rr_arb2 (2 requests, grant one-hot, pointer register).
REQ-034 No memory instance inside; memory is a sibling instance wired at parent.

Verification
REQ-035 Reset release -> init_busy high 256 cycles, writes addr 0..255 data 0 mask 2'b11, then RUN; reading addr 0x7F -> 20'h0.
REQ-036 RUN, both reads valid continuously (addr 0x10, 0x20) -> grants alternate 0,1,0,1; each resp one cycle after its grant.
REQ-037 Write addr 0x05 data 20'hABCDE mask 2'b01, previously 0 -> later read 0x05 returns 20'h000DE... i.e. low lane 10'h0DE, high lane 0.
REQ-038 Same-cycle write 0x33 data 20'h12345 mask 2'b11 and read 0x33 -> resp_data=20'h12345 next cycle.
REQ-039 clear_req with rd0 granted -> resp0_valid next cycle, init_busy next cycle, readies 0 for 256 cycles, prior data reads back 0.
REQ-040 reset asserted at clear counter=100 -> after release, clearing restarts at address 0, full 256 cycles.
